// File: rtl/button_array.sv
// -----------------------------------------------------------------------------
// button_array
// Multi-channel push-button conditioner. Each channel runs its own
// polarity correction, two-flop synchronizer, debouncer, edge detector and
// hold timer, producing a clean level plus one-cycle press, release,
// long-press and auto-repeat pulses.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   btn_in         raw asynchronous button inputs, one bit per channel
//   repeat_en      global auto-repeat enable, sampled every cycle
//   level          debounced pressed state (1 = pressed)
//   press_pulse    one cycle, coincident with the first pressed cycle of level
//   release_pulse  one cycle, coincident with the first released cycle of level
//   long_pulse     one cycle, LONG_CNT cycles after press_pulse
//   repeat_pulse   one cycle, every REPEAT_CNT cycles after long_pulse
//
// Hold FSM (one per channel)
//   state   | meaning
//   IDLE    | button released, hold timer idle
//   HELD    | pressed, counting towards the long-press terminal count
//   LONG    | long press reached, counting auto-repeat periods
// -----------------------------------------------------------------------------
module button_array #(
    parameter int N_CH         = 4,
    parameter int DEBOUNCE_CNT = 1000,
    parameter int LONG_CNT     = 500000,
    parameter int REPEAT_CNT   = 100000,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    input  logic            repeat_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    localparam int HOLD_MAX = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
    localparam int DW       = $clog2(DEBOUNCE_CNT);
    localparam int HW       = $clog2(HOLD_MAX);

    localparam logic [DW-1:0] DEB_TC  = DW'(DEBOUNCE_CNT - 1);
    localparam logic [HW-1:0] LONG_TC = HW'(LONG_CNT - 1);
    localparam logic [HW-1:0] REP_TC  = HW'(REPEAT_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } hold_state_e;

    logic [N_CH-1:0] btn_pol;
    logic [N_CH-1:0] sync1_q, sync1_d;
    logic [N_CH-1:0] sync2_q, sync2_d;
    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] release_q, release_d;
    logic [N_CH-1:0] long_q, long_d;
    logic [N_CH-1:0] repeat_q, repeat_d;

    logic [DW-1:0]   dcnt_q  [N_CH];
    logic [DW-1:0]   dcnt_d  [N_CH];
    logic [HW-1:0]   hcnt_q  [N_CH];
    logic [HW-1:0]   hcnt_d  [N_CH];
    hold_state_e     state_q [N_CH];
    hold_state_e     state_d [N_CH];

    // Polarity is fixed before the synchronizer so its reset value of 0 is
    // always the released level and reset release never fakes a press.
    assign btn_pol = ACTIVE_LOW ? ~btn_in : btn_in;
    assign sync1_d = btn_pol;
    assign sync2_d = sync1_q;

    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        repeat_d  = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            dcnt_d[ch]  = '0;
            hcnt_d[ch]  = hcnt_q[ch];
            state_d[ch] = state_q[ch];

            // Any sample agreeing with the current level restarts the count.
            if (sync2_q[ch] != level_q[ch]) begin
                if (dcnt_q[ch] == DEB_TC) begin
                    level_d[ch] = sync2_q[ch];
                end else begin
                    dcnt_d[ch] = dcnt_q[ch] + DW'(1);
                end
            end

            press_d[ch]   = level_d[ch] & ~level_q[ch];
            release_d[ch] = ~level_d[ch] & level_q[ch];

            // Release takes priority over a long/repeat terminal count in the
            // same cycle, so neither fires once the button has let go.
            if (release_d[ch]) begin
                state_d[ch] = ST_IDLE;
                hcnt_d[ch]  = '0;
            end else begin
                case (state_q[ch])
                    ST_IDLE: begin
                        if (press_d[ch]) begin
                            state_d[ch] = ST_HELD;
                            hcnt_d[ch]  = '0;
                        end
                    end
                    ST_HELD: begin
                        if (hcnt_q[ch] == LONG_TC) begin
                            long_d[ch]  = 1'b1;
                            state_d[ch] = ST_LONG;
                            hcnt_d[ch]  = '0;
                        end else begin
                            hcnt_d[ch] = hcnt_q[ch] + HW'(1);
                        end
                    end
                    ST_LONG: begin
                        if (!repeat_en) begin
                            hcnt_d[ch] = '0;
                        end else if (hcnt_q[ch] == REP_TC) begin
                            repeat_d[ch] = 1'b1;
                            hcnt_d[ch]   = '0;
                        end else begin
                            hcnt_d[ch] = hcnt_q[ch] + HW'(1);
                        end
                    end
                    default: begin
                        state_d[ch] = ST_IDLE;
                        hcnt_d[ch]  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            repeat_q  <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                dcnt_q[ch]  <= '0;
                hcnt_q[ch]  <= '0;
                state_q[ch] <= ST_IDLE;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            for (int ch = 0; ch < N_CH; ch++) begin
                dcnt_q[ch]  <= dcnt_d[ch];
                hcnt_q[ch]  <= hcnt_d[ch];
                state_q[ch] <= state_d[ch];
            end
        end
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: doc/button_array.md
# button_array

Multi-channel button conditioner that turns N raw push-button inputs into clean per-channel debounced levels plus one-cycle press, release, long-press and auto-repeat event pulses. It sits between the top-level input pins and the display/control logic, replacing per-button debouncer, synchronizer and one-shot chains with one parametrised block. The input is synchronized before debouncing. The block adds event types that the single-channel chain does not provide.

## Interface
- N_CH, 4: number of independent button channels (≥1).
- DEBOUNCE_CNT, 1000: consecutive stable cycles required to accept a level change (≥2).
- LONG_CNT, 500000: cycles from the press pulse to the long-press pulse (≥2).
- REPEAT_CNT, 100000: auto-repeat period in cycles after long press (≥2).
- ACTIVE_LOW, 0: 1 means a pressed button drives btn_in low. Inputs are inverted before the synchronizer.
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_in  in  N_CH  raw asynchronous button inputs.
- repeat_en  in  1  global auto-repeat enable, sampled each cycle.
- level  out  N_CH  debounced pressed state (1 = pressed).
- press_pulse  out  N_CH  one-cycle pulse when level rises.
- release_pulse  out  N_CH  one-cycle pulse when level falls.
- long_pulse  out  N_CH  one-cycle pulse when LONG_CNT is reached.
- repeat_pulse  out  N_CH  one-cycle auto-repeat pulse.

## Operation
- **Channels.** Channels are fully independent. All logic described here is replicated per channel.
- **Synchronizer.** Two-flop synchronizer on the polarity-corrected input.
  - Reset value is 0 (the inactive level), so no press is generated on reset release.
- **Debouncer.**
  - Counter dcnt has width $clog2(DEBOUNCE_CNT).
  - If the sync output equals level: dcnt <= 0.
  - Otherwise, if dcnt == DEBOUNCE_CNT-1: level <= sync and dcnt <= 0.
  - Otherwise: dcnt++.
  - Any bounce back to the current level restarts the count.
- **Edge pulses.** press_pulse and release_pulse are registered in the same edge that updates level. They are therefore coincident with the first cycle of the new level.
- **Hold FSM.**
  - States: IDLE, HELD, LONG.
  - Counter hcnt has width $clog2(max(LONG_CNT, REPEAT_CNT)).
  - IDLE: on level rise, go to HELD with hcnt <= 0.
  - HELD: each cycle hcnt++. When hcnt == LONG_CNT-1, assert long_pulse, go to LONG and set hcnt <= 0.
  - LONG with repeat_en=1: each cycle hcnt++. When hcnt == REPEAT_CNT-1, assert repeat_pulse and set hcnt <= 0.
  - LONG with repeat_en=0: hcnt <= 0. The first repeat comes REPEAT_CNT cycles after re-enable.
  - Level fall in any state: go to IDLE and clear hcnt. A long or repeat terminal count falling in the same cycle as the release is suppressed; release wins.
- **Pulse width.** Every pulse output is exactly one cycle wide. Counters never wrap past their terminal values.

## Timing
- **Reset state.** While reset = 0, all outputs are 0, the synchronizer is 0, dcnt = hcnt = 0 and the FSM is in IDLE. This holds asynchronously, immediately.
- **Input latency.** Take edge 1 as the first edge that samples a new btn_in value. level changes, and press_pulse/release_pulse fire, at edge DEBOUNCE_CNT+2, provided the input is stable throughout.
- **Long press.** long_pulse fires LONG_CNT cycles after press_pulse.
- **Auto-repeat.** repeat_pulse fires REPEAT_CNT, 2·REPEAT_CNT, … cycles after long_pulse while the button is held and repeat_en=1.
- **Reset mid-operation.** All state is discarded. If the button is still held after reset is released, it is treated as a new press: press_pulse fires at edge DEBOUNCE_CNT+2 after release.
- **Simultaneous events.** Events on multiple channels in the same cycle each produce their own pulses, with no arbitration.

## Test plan
All scenarios use N_CH=2, DEBOUNCE_CNT=4, LONG_CNT=10, REPEAT_CNT=3 and ACTIVE_LOW=0 unless stated otherwise.

- **Reset.** Assert reset with btn_in=2'b11, then release it -> all outputs 0 during reset. level=2'b11 and press_pulse=2'b11 for exactly one cycle at edge 6 after release.
- **Clean press.** Raise btn_in[0] before edge 1 -> level[0] and press_pulse[0] at edge 6. No long_pulse before 10 cycles later.
- **Bounce rejection.** btn_in[0] high for 3 cycles then low -> level, press_pulse and release_pulse stay 0. A 5-cycle high is accepted.
- **Long press and repeat.** Hold ch0 with repeat_en=1 -> long_pulse 10 cycles after press_pulse, then repeat_pulse at +3, +6, +9. Releasing -> release_pulse 6 edges after the input falls, with no further repeats.
- **Repeat disabled, independent channels.** Hold ch0 and ch1 with repeat_en=0, ch1 pressed 2 cycles later -> both long_pulses fire, 2 cycles apart, with no repeat_pulse. Setting repeat_en=1 -> first repeat 3 cycles later.
- **Inverted polarity and reset mid-hold.** ACTIVE_LOW=1: btn_in[0]=0 gives press_pulse[0] at edge 6. Resetting in the HELD state -> no long_pulse. After reset is released, a new press_pulse fires at edge 6.
